// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: op codes, FSM states,
// the legal data address window and small decode helpers.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [31:0] stack_size_lo = 32'h0000_1000;
  localparam logic [31:0] stack_size_hi = 32'h0000_1FFF;

  function automatic logic is_load(lsu_op_e op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  // Halfwords need an even address, words need offset 0.
  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] offset);
    case (op)
      OP_LH, OP_LHU, OP_SH: return offset[0];
      OP_LW, OP_SW:         return offset != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response channel of the load/store unit.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  lsu_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Big-endian byte/halfword lane extraction for loads and lane merge for
// partial stores; purely combinational.
module lane_align
  import load_store_unit_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane_byte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane 0 is the most significant byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       hit;
    logic [7:0] src;

    assign lane_byte[gi] = word[31-8*gi -: 8];
    assign hit = ((op == OP_SB) && (offset == LANE)) ||
                 ((op == OP_SH) && (offset[1] == LANE[1]));
    assign src = ((op == OP_SB) || LANE[0]) ? wdata[7:0] : wdata[15:8];
    assign merged_word[31-8*gi -: 8] = hit ? src : lane_byte[gi];
  end

  assign byte_sel = lane_byte[offset];
  assign half_sel = offset[1] ? word[15:0] : word[31:16];

  always_comb begin
    load_data = word;
    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with read-modify-write for SB/SH and
// address-window faults. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = stack_size_lo,
  parameter logic [31:0] ADDR_HI = stack_size_hi
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  output logic               mem_sig_mem_write,
  input  logic [31:0]        mem_read_data
);

  lsu_state_e  state_reg, state_next;
  lsu_op_e     op_reg;
  logic [31:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [31:0] word_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic        req_fault;
  logic        req_ready;
  logic        resp_valid;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  always_comb begin
    req_fault = (bus.req_addr < ADDR_LO) || (bus.req_addr > ADDR_HI);
`ifdef MISALIGN_TRAP_EN
    req_fault = req_fault || is_misaligned(bus.req_op, bus.req_addr[1:0]);
`endif
  end

  lane_align u_lane_align (
    .op          (op_reg),
    .offset      (addr_reg[1:0]),
    .word        (mem_read_data),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next        = state_reg;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    mem_addr          = 32'h0;
    mem_write_data    = 32'h0;
    mem_sig_mem_write = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (req_fault)                state_next = RESP;
          else if (bus.req_op == OP_SW) state_next = WR;
          else                          state_next = RD;
        end
      end
      RD: begin
        mem_addr   = {addr_reg[31:2], 2'b00};
        state_next = is_load(op_reg) ? RESP : WR;
      end
      WR: begin
        mem_addr          = {addr_reg[31:2], 2'b00};
        mem_write_data    = word_reg;
        mem_sig_mem_write = 1'b1;
        state_next        = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = req_ready && bus.req_valid;

  // word_reg holds the SW data directly, or the merged RMW word from RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg    <= OP_LB;
      addr_reg  <= 32'h0;
      wdata_reg <= 16'h0;
      word_reg  <= 32'h0;
      rdata_reg <= 32'h0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      op_reg    <= bus.req_op;
      addr_reg  <= bus.req_addr;
      wdata_reg <= bus.req_wdata[15:0];
      word_reg  <= bus.req_wdata;
      rdata_reg <= 32'h0;
      err_reg   <= req_fault;
    end else if (state_reg == RD) begin
      if (is_load(op_reg)) rdata_reg <= load_data;
      else                 word_reg  <= merged_word;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_valid ? rdata_reg : 32'h0;
  assign bus.resp_err   = resp_valid & err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small word memory
// model; honours MISALIGN_TRAP_EN for the misaligned-word vector.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_sig_mem_write;
  logic [31:0] mem_read_data;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .mem_sig_mem_write (mem_sig_mem_write),
    .mem_read_data     (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word memory covering 0x1000..0x1FFF, combinational read.
  logic [31:0] mem [1024];
  logic        mem_init;
  int          strobe_cnt;
  logic [31:0] last_wdata;

  assign mem_read_data = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8899_AABB;
      strobe_cnt = 0;
      last_wdata = 32'h0;
    end else if (mem_sig_mem_write) begin
      mem[mem_addr[11:2]] <= mem_write_data;
      strobe_cnt = strobe_cnt + 1;
      last_wdata = mem_write_data;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_strobes;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int n_vec;
  int n_miscomp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int s0;
    n_vec++;
    @(negedge clk);
    check($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_op     = lsu_op_e'(v.op);
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.resp_ready = 1'b1;
    s0 = strobe_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d rdata", idx), bus.resp_rdata, v.exp_rdata);
    check($sformatf("v%0d err", idx), 32'(bus.resp_err), 32'(v.exp_err));
    check($sformatf("v%0d strobes", idx), 32'(strobe_cnt - s0), 32'(v.exp_strobes));
    if (v.exp_strobes != 0)
      check($sformatf("v%0d wdata", idx), last_wdata, v.exp_wdata);
    @(posedge clk);
    #1;
    check($sformatf("v%0d resp_drop", idx), 32'(bus.resp_valid), 32'd0);
    $display("vec %0d op=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
             idx, v.op, v.addr, v.exp_rdata, v.exp_err, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rv_seen;
    n_vec     = 0;
    n_miscomp = 0;

    //            op      addr          wdata         rdata         err lat st  wword
    vecs[0]  = '{3'd0, 32'h1001, 32'h0,        32'hFFFF_FF99, 1'b0, 2, 0, 32'h0};
    vecs[1]  = '{3'd1, 32'h1003, 32'h0,        32'h0000_00BB, 1'b0, 2, 0, 32'h0};
    vecs[2]  = '{3'd2, 32'h1000, 32'h0,        32'hFFFF_8899, 1'b0, 2, 0, 32'h0};
    vecs[3]  = '{3'd3, 32'h1002, 32'h0,        32'h0000_AABB, 1'b0, 2, 0, 32'h0};
    vecs[4]  = '{3'd4, 32'h1000, 32'h0,        32'h8899_AABB, 1'b0, 2, 0, 32'h0};
    vecs[5]  = '{3'd5, 32'h1002, 32'h0000_0011, 32'h0,        1'b0, 3, 1, 32'h8899_11BB};
    vecs[6]  = '{3'd4, 32'h1000, 32'h0,        32'h8899_11BB, 1'b0, 2, 0, 32'h0};
    vecs[7]  = '{3'd6, 32'h1000, 32'hFFFF_1234, 32'h0,        1'b0, 3, 1, 32'h1234_11BB};
    vecs[8]  = '{3'd7, 32'h1004, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 1, 32'hDEAD_BEEF};
    vecs[9]  = '{3'd3, 32'h1006, 32'h0,        32'h0000_BEEF, 1'b0, 2, 0, 32'h0};
    vecs[10] = '{3'd2, 32'h1004, 32'h0,        32'hFFFF_DEAD, 1'b0, 2, 0, 32'h0};
    vecs[11] = '{3'd4, 32'h2003, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
    vecs[12] = '{3'd5, 32'h0FFF, 32'h0000_0055, 32'h0,        1'b1, 1, 0, 32'h0};
    vecs[13] = '{3'd0, 32'h1FFF, 32'h0,        32'h0,         1'b0, 2, 0, 32'h0};
`ifdef MISALIGN_TRAP_EN
    vecs[14] = '{3'd4, 32'h1002, 32'h0,        32'h0,         1'b1, 1, 0, 32'h0};
`else
    vecs[14] = '{3'd4, 32'h1002, 32'h0,        32'h1234_11BB, 1'b0, 2, 0, 32'h0};
`endif
    vecs[15] = '{3'd5, 32'h1007, 32'h0000_00A5, 32'h0,        1'b0, 3, 1, 32'hDEAD_BEA5};

    rst            = 1'b1;
    mem_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_op     = OP_LB;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'h0);
    check("rst strobe", 32'(mem_sig_mem_write), 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_write_data, 32'h0);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    $display("reset state checked");
    mem_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Held response, then no accept in the cycle the response is taken.
    n_vec++;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_LW;
    bus.req_addr   = 32'h1004;
    bus.resp_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold latency", 32'(lat), 32'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold valid", 32'(bus.resp_valid), 32'd1);
      check("hold rdata", bus.resp_rdata, 32'hDEAD_BEA5);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_op     = OP_LB;
    bus.req_addr   = 32'h1000;
    @(posedge clk);
    #1;
    check("nobypass resp_valid", 32'(bus.resp_valid), 32'd0);
    check("nobypass req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("accept after idle", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("post rdata", bus.resp_rdata, 32'h0000_0012);
    @(posedge clk);
    #1;
    $display("hold/no-bypass sequence done lat=%0d", lat);

    // Reset during the WR cycle of an SB.
    n_vec++;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_SB;
    bus.req_addr  = 32'h1000;
    bus.req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rmw strobe in WR", 32'(mem_sig_mem_write), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst strobe drop", 32'(mem_sig_mem_write), 32'd0);
    check("rst mem_addr drop", mem_addr, 32'h0);
    check("rst mem_wdata drop", mem_write_data, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst mem unchanged", mem[0], 32'h1234_11BB);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    rv_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) rv_seen++;
    end
    check("rst no resp", 32'(rv_seen), 32'd0);
    check("rst mem final", mem[0], 32'h1234_11BB);
    $display("reset-in-WR sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
